uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   UART transmitter that serialises bytes onto the asynchronous line.
//   Sits directly upstream of the uart receiver: its tx output drives the receiver's rx input.
//   Accepts a byte through a valid/ready handshake.
//   Emits start bit, data bits LSB-first, optional parity and stop bit(s); idle level is high.
// PARAMETERS
//   CLK_FREQ   50_000_000  sclk frequency in Hz
//   BAUD       115_200     line bit rate in bit/s
//   DATA_BITS  8           data bits per frame, legal range 5..8
//   STOP_BITS  1           stop bits per frame, legal values 1 or 2
//   CLKS_PER_BIT is a localparam = CLK_FREQ/BAUD, integer-truncated; must be >= 2
// PORTS
//   sclk      in   1          system clock; all logic is on the rising edge
//   srst_n    in   1          reset; asynchronous, active-low
//   tx_data   in   DATA_BITS  byte to send; sampled only on the accept cycle
//   tx_valid  in   1          tx_data is valid
//   tx_ready  out  1          block can accept a byte
//   tx        out  1          serial line; registered, idle high
//   tx_busy   out  1          a frame is in progress
//   tx_done   out  1          one-cycle pulse in the last cycle of the final stop bit
// BEHAVIOUR
//   Reset values (asynchronous assertion):
//     tx=1, tx_ready=1, tx_busy=0, tx_done=0; state IDLE; all counters 0.
//   Handshake:
//     Accept occurs on a cycle where tx_valid && tx_ready; tx_data is latched into the shift register.
//     tx_ready=1 only in IDLE. tx_valid while busy is ignored, not queued.
//   FSM states and transitions:
//     IDLE -> START on accept.
//     START -> DATA after CLKS_PER_BIT cycles.
//     DATA -> PARITY (if enabled) or STOP after DATA_BITS bits.
//     PARITY -> STOP.
//     STOP -> IDLE after STOP_BITS*CLKS_PER_BIT cycles.
//   Timing:
//     tx drops to 0 on the cycle after accept (1-cycle latency).
//     Each bit is held exactly CLKS_PER_BIT cycles.
//     tx_busy=1 in every state except IDLE.
//     Frame length = (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with parity, else 0.
//   Back-to-back frames: with tx_valid held, exactly one idle-high cycle separates consecutive frames
//     (the IDLE accept cycle).
//   Counters:
//     Baud counter width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, then wraps to 0.
//     Bit counter width $clog2(DATA_BITS+1).
//   Reset mid-frame: tx returns high immediately; frame abandoned; no tx_done.
//   tx_data changing after accept has no effect on the frame in flight.
// CONFIGURATION
//   UART_TX_PARITY_EN defined:
//     Even-parity bit (XOR of the latched data bits) is inserted between the last data bit and the stop bit.
//   UART_TX_PARITY_EN undefined:
//     No PARITY state; frame is 8N1 or 8N2.
// STRUCTURE
//   Shared package uart_pkg:
//     FSM state encoding (IDLE/START/DATA/PARITY/STOP).
//     Line-level constants LINE_IDLE=1 and START_LVL=0.
//     Function clks_per_bit(CLK_FREQ, BAUD), shared with the receiver.
//   Sub-module uart_baud_gen:
//     Per-bit tick counter; cleared on accept; emits tick every CLKS_PER_BIT cycles while enabled.
// TESTING (bench with CLK_FREQ=16, BAUD=1 -> 16 clocks/bit; parity off unless stated)
//   1. Reset: hold srst_n=0 for 3 cycles, then release -> tx=1, tx_ready=1, tx_busy=0, tx_done=0.
//   2. Send 0xB9 -> line 0,1,0,0,1,1,1,0,1,1, each 16 cycles; tx_done pulses at cycle 160 after accept;
//      tx_ready returns next cycle.
//   3. Hold tx_valid with 0x00 then 0xFF -> two frames; exactly 1 high cycle between the 0x00 stop bit
//      and the 0xFF start bit.
//   4. Assert srst_n=0 during data bit 3 of 0x55 -> tx=1 in the same cycle; no tx_done;
//      a fresh 0xA5 after release is sent correctly.
//   5. UART_TX_PARITY_EN with 0xB9 (five ones) -> parity bit 1 after the MSB; frame is 176 cycles.
//   6. Loopback into the uart receiver with 0xB9 -> receiver data output = 0xB9;
//      tx_valid pulses during busy leave the frame unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and baud divisor helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;

    // Integer-truncated clocks per line bit; callers must keep the result >= 2.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Per-bit tick generator: counts 0..CLKS_PER_BIT-1 while enabled, restarts on clear.
// o_pre_tick flags the cycle before o_tick so callers can mark the last cycle of a bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tick,
    output logic o_pre_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || !i_en || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick     = i_en && w_last;
    assign o_pre_tick = i_en && (r_cnt == CNT_PRE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, start + LSB-first data + stop bit(s), idle-high line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 sclk,
    input  logic                 srst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int BIT_W        = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic LAST_STOP  = (STOP_BITS == 2);

    uart_state_t          r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_tx;
    logic                 r_done;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic w_idle;
    logic w_accept;
    logic w_tick;
    logic w_pre_tick;
    logic w_last_stop;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_accept    = tx_valid && w_idle;
    assign w_last_stop = (r_stop_cnt == LAST_STOP);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk      (sclk),
        .i_rst_n    (srst_n),
        .i_clear    (w_accept),
        .i_en       (!w_idle),
        .o_tick     (w_tick),
        .o_pre_tick (w_pre_tick)
    );

    // The line level is registered and set one cycle ahead of each bit period.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= LINE_IDLE;
            r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state    <= ST_START;
                        r_shift    <= tx_data;
                        r_bit_cnt  <= '0;
                        r_stop_cnt <= 1'b0;
                        r_tx       <= START_LVL;
`ifdef UART_TX_PARITY_EN
                        r_parity   <= ^tx_data;
`endif
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            r_state   <= ST_PARITY;
                            r_tx      <= r_parity;
`else
                            r_state   <= ST_STOP;
                            r_tx      <= LINE_IDLE;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_state <= ST_STOP;
                        r_tx    <= LINE_IDLE;
                    end
                end
`endif
                ST_STOP: begin
                    // Pulse lands in the final cycle of the last stop bit.
                    if (w_pre_tick && w_last_stop) begin
                        r_done <= 1'b1;
                    end
                    if (w_tick) begin
                        if (w_last_stop) begin
                            r_state    <= ST_IDLE;
                            r_stop_cnt <= 1'b0;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= LINE_IDLE;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign tx_ready = w_idle;
    assign tx_busy  = !w_idle;
    assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 16 clocks/bit: line shape, timing, back-to-back, reset abort.
// A serial decoder on the line pops expected bytes from a scoreboard queue.
module tb_uart_tx;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = 1 + 8 + PB + 1;
    localparam int FL = NB * CPB;

    logic       sclk;
    logic       srst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int         n_checks;
    int         n_errors;
    int         n_frames;
    logic [7:0] rx_last;
    logic [7:0] sb_q[$];

    uart_tx #(
        .CLK_FREQ (16),
        .BAUD     (1),
        .DATA_BITS(8),
        .STOP_BITS(1)
    ) dut (
        .sclk    (sclk),
        .srst_n  (srst_n),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] frame_bits(input logic [7:0] b);
        logic [11:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = b[i];
        if (PB == 1) f[9] = ^b;
        return f;
    endfunction

    // Line decoder acting as the downstream receiver; samples mid-bit.
    logic [11:0] mon_bits;
    bit          mon_abort;
    logic [7:0]  mon_exp;
    initial begin : monitor
        forever begin
            @(negedge sclk);
            if (srst_n === 1'b1 && tx === 1'b0) begin
                mon_abort = 1'b0;
                mon_bits  = '1;
                for (int k = 0; k < NB; k++) begin
                    for (int w = 0; w < ((k == 0) ? (CPB / 2 - 1) : CPB); w++) begin
                        @(negedge sclk);
                        if (srst_n !== 1'b1) begin
                            mon_abort = 1'b1;
                            break;
                        end
                    end
                    if (mon_abort) break;
                    mon_bits[k] = tx;
                end
                if (!mon_abort) begin
                    check_eq("sb_nonempty", 32'(sb_q.size() > 0), 1);
                    mon_exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
                    check_eq("rx_start", mon_bits[0], 1'b0);
                    check_eq("rx_data", mon_bits[8:1], mon_exp);
`ifdef UART_TX_PARITY_EN
                    check_eq("rx_parity", mon_bits[9], ^mon_exp);
`endif
                    check_eq("rx_stop", mon_bits[NB-1], 1'b1);
                    rx_last = mon_bits[8:1];
                    n_frames++;
                end
            end
        end
    end

    task automatic send_and_check(input logic [7:0] b, input bit noise);
        logic [11:0] bits;
        int bad_line, bad_busy, bad_ready, done_cnt, done_at;
        bits = frame_bits(b);
        bad_line = 0; bad_busy = 0; bad_ready = 0; done_cnt = 0; done_at = 0;
        @(negedge sclk);
        check_eq("ready_before", tx_ready, 1'b1);
        tx_data  = b;
        tx_valid = 1'b1;
        sb_q.push_back(b);
        @(posedge sclk);
        #1;
        tx_valid = 1'b0;
        tx_data  = ~b;
        for (int c = 1; c <= FL; c++) begin
            @(negedge sclk);
            if (noise) begin
                tx_valid = (c >= 20 && c < 100) ? c[0] : 1'b0;
                tx_data  = 8'h3C;
            end
            if (c == 1) check_eq("start_latency", tx, 1'b0);
            if (tx !== bits[(c - 1) / CPB]) bad_line++;
            if (tx_busy !== 1'b1) bad_busy++;
            if (tx_ready !== 1'b0) bad_ready++;
            if (tx_done === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
        end
        check_eq("line_shape_errs", bad_line, 0);
        check_eq("busy_errs", bad_busy, 0);
        check_eq("ready_in_frame_errs", bad_ready, 0);
        check_eq("done_pulses", done_cnt, 1);
        check_eq("done_cycle", done_at, FL);
        @(negedge sclk);
        check_eq("ready_after", tx_ready, 1'b1);
        check_eq("busy_after", tx_busy, 1'b0);
        check_eq("done_after", tx_done, 1'b0);
        check_eq("tx_after", tx, 1'b1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int start2, waited, bad_rst;
        n_checks = 0; n_errors = 0; n_frames = 0; rx_last = 8'h00;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        srst_n   = 1'b1;
        #1 srst_n = 1'b0;

        // Reset state
        repeat (3) @(negedge sclk);
        check_eq("rst_tx", tx, 1'b1);
        check_eq("rst_ready", tx_ready, 1'b1);
        check_eq("rst_busy", tx_busy, 1'b0);
        check_eq("rst_done", tx_done, 1'b0);
        srst_n = 1'b1;
        @(negedge sclk);
        check_eq("post_rst_tx", tx, 1'b1);
        check_eq("post_rst_ready", tx_ready, 1'b1);
        check_eq("post_rst_busy", tx_busy, 1'b0);
        check_eq("post_rst_done", tx_done, 1'b0);

        // Single frame
        send_and_check(8'hB9, 1'b0);

        // Back-to-back with tx_valid held
        @(negedge sclk);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        sb_q.push_back(8'h00);
        sb_q.push_back(8'hFF);
        @(posedge sclk);
        #1 tx_data = 8'hFF;
        start2 = 0;
        for (int c = 1; c <= FL + 4; c++) begin
            @(negedge sclk);
            if (c == FL) check_eq("b2b_stop_level", tx, 1'b1);
            if (c == FL + 1) begin
                check_eq("b2b_idle_ready", tx_ready, 1'b1);
                check_eq("b2b_idle_level", tx, 1'b1);
            end
            if (start2 == 0 && c > FL && tx === 1'b0) begin
                start2   = c;
                tx_valid = 1'b0;
            end
        end
        tx_valid = 1'b0;
        check_eq("b2b_gap_cycles", start2 - FL - 1, 1);
        waited = 0;
        while (tx_busy !== 1'b0 && waited < 2 * FL) begin
            @(negedge sclk);
            waited++;
        end
        check_eq("b2b_end_timeout", 32'(waited < 2 * FL), 1);

        // Reset during data bit 3 of 0x55
        @(negedge sclk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(posedge sclk);
        #1 tx_valid = 1'b0;
        repeat (70) @(negedge sclk);
        check_eq("d3_level", tx, 1'b0);
        srst_n = 1'b0;
        #1;
        check_eq("abort_tx", tx, 1'b1);
        check_eq("abort_busy", tx_busy, 1'b0);
        check_eq("abort_ready", tx_ready, 1'b1);
        check_eq("abort_done", tx_done, 1'b0);
        bad_rst = 0;
        repeat (4) begin
            @(negedge sclk);
            if (tx_done !== 1'b0 || tx !== 1'b1) bad_rst++;
        end
        srst_n = 1'b1;
        repeat (20) begin
            @(negedge sclk);
            if (tx_done !== 1'b0 || tx !== 1'b1) bad_rst++;
        end
        check_eq("abort_quiet_errs", bad_rst, 0);
        send_and_check(8'hA5, 1'b0);

        // Frame with tx_valid noise while busy
        send_and_check(8'hB9, 1'b1);

        repeat (4) @(negedge sclk);
        check_eq("rx_last", rx_last, 8'hB9);
        check_eq("frames_seen", n_frames, 5);
        check_eq("sb_leftover", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
